// File: rtl/accel_pkg.sv
// Shared types, default widths and phase-length helpers for the tile sequencer.
package accel_pkg;

  localparam int unsigned DefaultArraySize = 4;
  localparam int unsigned DefaultKWidth    = 8;
  localparam int unsigned DefaultAddrWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StFlush,
    StDrain,
    StDone
  } seq_state_t;

  // Counter reload values are "length - 1" so the zero flag marks the last phase cycle.
  function automatic int unsigned load_w_last(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned flush_last(input int unsigned n);
    return (n > 1) ? 2 * n - 3 : 0;
  endfunction

  function automatic int unsigned drain_last(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned row_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned kw);
    int unsigned w;
    w = $clog2(2 * n);
    return (kw > w) ? kw : w;
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable down-counter with a zero flag; times every sequencer phase.
module seq_phase_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/accel_tile_sequencer.sv
// Tile sequencer: accepts a tile command and drives weight load, input streaming,
// skew flush and result drain for the systolic-array datapath.
module accel_tile_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DefaultArraySize,
  parameter int unsigned K_WIDTH    = DefaultKWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  localparam int unsigned RowW      = row_width(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [K_WIDTH-1:0]    cmd_k,
  input  logic                  cmd_relu,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic                  abort,
  output logic                  sa_clear,
  output logic                  sa_load_w,
  output logic [RowW-1:0]       w_row,
  output logic                  sa_feed_valid,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_rd_addr,
  output logic                  buf_wr_en,
  input  logic                  buf_wr_ready,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic                  relu_en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = cnt_width(ARRAY_SIZE, K_WIDTH);
  localparam logic [CntW-1:0] LoadWLast = CntW'(load_w_last(ARRAY_SIZE));
  localparam logic [CntW-1:0] FlushLast = CntW'(flush_last(ARRAY_SIZE));
  localparam logic [CntW-1:0] DrainLast = CntW'(drain_last(ARRAY_SIZE));
  localparam bit HasFlush = (ARRAY_SIZE > 1);

  seq_state_t state_q, state_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic                  relu_q, relu_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [RowW-1:0]       w_row_q, w_row_d;
  logic [RowW-1:0]       col_q, col_d;
  logic                  clear_q, clear_d;

  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0] cnt_val;

  seq_phase_counter #(
    .Width(CntW)
  ) u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    relu_d    = relu_q;
    base_d    = base_q;
    in_addr_d = in_addr_q;
    w_row_d   = w_row_q;
    col_d     = col_q;
    clear_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = LoadWLast;

    if ((state_q != StIdle) && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort is ignored here, so a coincident command is still taken
          if (cmd_valid) begin
            k_d       = cmd_k;
            relu_d    = cmd_relu;
            base_d    = cmd_base;
            in_addr_d = '0;
            w_row_d   = '0;
            col_d     = '0;
            if (cmd_k == '0) begin
              state_d = StDone;
            end else begin
              state_d  = StLoadW;
              clear_d  = 1'b1;
              cnt_load = 1'b1;
              cnt_val  = LoadWLast;
            end
          end
        end
        StLoadW: begin
          w_row_d = w_row_q + RowW'(1);
          cnt_dec = 1'b1;
          if (cnt_zero) begin
            state_d  = StStream;
            cnt_load = 1'b1;
            cnt_val  = CntW'(k_q) - CntW'(1);
          end
        end
        StStream: begin
          in_addr_d = in_addr_q + ADDR_WIDTH'(1);
          cnt_dec   = 1'b1;
          if (cnt_zero) begin
            cnt_load = 1'b1;
            if (HasFlush) begin
              state_d = StFlush;
              cnt_val = FlushLast;
            end else begin
              state_d = StDrain;
              cnt_val = DrainLast;
            end
          end
        end
        StFlush: begin
          cnt_dec = 1'b1;
          if (cnt_zero) begin
            state_d  = StDrain;
            cnt_load = 1'b1;
            cnt_val  = DrainLast;
          end
        end
        StDrain: begin
          // Column and counter advance only on an accepted write
          if (buf_wr_ready) begin
            col_d   = col_q + RowW'(1);
            cnt_dec = 1'b1;
            if (cnt_zero) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      relu_q    <= 1'b0;
      base_q    <= '0;
      in_addr_q <= '0;
      w_row_q   <= '0;
      col_q     <= '0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      relu_q    <= relu_d;
      base_q    <= base_d;
      in_addr_q <= in_addr_d;
      w_row_q   <= w_row_d;
      col_q     <= col_d;
      clear_q   <= clear_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign sa_clear      = clear_q;
  assign sa_load_w     = (state_q == StLoadW);
  assign sa_feed_valid = (state_q == StStream);
  assign in_rd_en      = (state_q == StStream);
  assign buf_wr_en     = (state_q == StDrain);
  assign relu_en       = relu_q && (state_q != StIdle);
  assign w_row         = w_row_q;
  assign in_rd_addr    = in_addr_q;
  assign buf_wr_addr   = base_q + ADDR_WIDTH'(col_q);

endmodule
